uart_rx_param: RTL and testbench

Parametrised successor to the team's fixed 7-bit Hamming UART receiver, used in the same Tiny Tapeout datapath.
- Configurable data width, oversampling ratio, parity mode, stop-bit count and line polarity.
- Adds an input synchroniser, 3-sample majority voting and per-word parity/framing error flags.
- Adds a valid/ready output register with overrun detection, feeding the downstream Hamming decoder or FIFO.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 55 +++++
 rtl/uart_rx_param.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and the
// 2-of-3 majority helper used by the receive sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: two-flop synchroniser, polarity correction and a 2-of-3
// majority vote across the middle of each bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int  OVERSAMPLE = 8,
    parameter int  INVERT     = 0,
    localparam int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          rx,
    input  logic [CW-1:0] cnt,
    output logic          l,
    output logic          vote
);

    localparam int            M          = OVERSAMPLE / 2;
    localparam logic          INV_BIT    = (INVERT != 0);
    localparam logic          RAW_IDLE   = ~INV_BIT;
    localparam logic [CW-1:0] CNT_FIRST  = CW'(M - 1);
    localparam logic [CW-1:0] CNT_SECOND = CW'(M);

    logic sync1;
    logic sync2;
    logic sample0;
    logic sample1;

    // The synchroniser must run every cycle so the line is never seen stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    assign l = sync2 ^ INV_BIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample0 <= 1'b1;
            sample1 <= 1'b1;
        end else if (ena) begin
            if (cnt == CNT_FIRST) sample0 <= l;
            if (cnt == CNT_SECOND) sample1 <= l;
        end
    end

    assign vote = majority3(sample0, sample1, l);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-voted sampling, parity/framing
// flags and a valid/ready output register that reports dropped frames.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 7,
    parameter int OVERSAMPLE  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int INVERT      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    input  logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int            CW        = $clog2(OVERSAMPLE);
    localparam int            IW        = $clog2(DATA_BITS);
    localparam int            M         = OVERSAMPLE / 2;
    localparam logic [CW-1:0] CNT_VOTE  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_n;
    logic                 stop_idx, stop_idx_n;
    logic                 ferr_acc, ferr_n;
    logic                 l, vote;
    logic                 cnt_wrap, cnt_at_vote;
    logic                 ferr_now, perr, complete;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE),
        .INVERT    (INVERT)
    ) u_sampler (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .rx   (rx),
        .cnt  (cnt),
        .l    (l),
        .vote (vote)
    );

    assign cnt_wrap    = (cnt == CNT_LAST);
    assign cnt_at_vote = (cnt == CNT_VOTE);
    assign ferr_now    = ferr_acc | ~vote;
    assign perr        = (PARITY_MODE != PARITY_NONE) &&
                         ((^shreg ^ par_bit) != (PARITY_MODE == PARITY_ODD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            par_bit  <= par_n;
            stop_idx <= stop_idx_n;
            ferr_acc <= ferr_n;
        end
    end

    // The last stop bit completes at its vote point rather than at the end of
    // the bit, leaving half a bit of slack to catch the next start edge.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        par_n      = par_bit;
        stop_idx_n = stop_idx;
        ferr_n     = ferr_acc;
        complete   = 1'b0;
        if (ena) begin
            cnt_n = cnt_wrap ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (!l) begin
                        state_n    = START;
                        stop_idx_n = 1'b0;
                        ferr_n     = 1'b0;
                    end
                end
                START: begin
                    if (cnt_at_vote && vote) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt_wrap) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
                DATA: begin
                    if (cnt_at_vote) shreg_n = {vote, shreg[DATA_BITS-1:1]};
                    if (cnt_wrap) begin
                        if (bit_idx == IDX_LAST) begin
                            state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                        end else begin
                            bit_idx_n = bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_at_vote) par_n = vote;
                    if (cnt_wrap) state_n = STOP;
                end
                STOP: begin
                    if (cnt_at_vote) begin
                        ferr_n = ferr_now;
                        if (stop_idx == STOP_LAST) begin
                            complete = 1'b1;
                            state_n  = IDLE;
                            cnt_n    = '0;
                        end
                    end else if (cnt_wrap) begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // A word accepted in the same cycle a new one completes frees the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else if (complete && (!valid_out || ready_in)) begin
            data_out   <= shreg;
            valid_out  <= 1'b1;
            parity_err <= perr;
            frame_err  <= ferr_now;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

    assign overrun = complete && valid_out && !ready_in;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: a normal-polarity and an inverted-line
// instance receive the same frames; a monitor pops expected words on handshake.
module tb_uart_rx_param;

    localparam int DW   = 7;
    localparam int OS   = 8;
    localparam int PM   = 1;
    localparam int SB   = 1;
    localparam int M    = OS / 2;
    localparam int PB   = (PM != 0) ? 1 : 0;
    // Cycle of the final stop vote counted from the cycle the line is seen low,
    // then the bench-span index where that cycle falls (two synchroniser flops).
    localparam int COMP = 1 + (DW + PB + SB) * OS + M + 1;
    localparam int LAT  = COMP + 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n, ena, rx, rx_inv, ready_in;
    logic [DW-1:0] data0, data1;
    logic          valid0, valid1, perr0, perr1, ferr0, ferr1;
    logic          ovr0, ovr1, busy0, busy1;

    int    vectors     = 0;
    int    miscompares = 0;
    int    exp_ovr     = 0;
    int    ovr_seen0   = 0;
    int    ovr_seen1   = 0;
    word_t exp_q0[$];
    word_t exp_q1[$];

    assign rx_inv = ~rx;

    uart_rx_param #(
        .DATA_BITS(DW), .OVERSAMPLE(OS), .PARITY_MODE(PM), .STOP_BITS(SB), .INVERT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx), .ready_in(ready_in),
        .data_out(data0), .valid_out(valid0), .parity_err(perr0),
        .frame_err(ferr0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_param #(
        .DATA_BITS(DW), .OVERSAMPLE(OS), .PARITY_MODE(PM), .STOP_BITS(SB), .INVERT(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx_inv), .ready_in(ready_in),
        .data_out(data1), .valid_out(valid1), .parity_err(perr1),
        .frame_err(ferr1), .overrun(ovr1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkWord(input int id, input logic [DW-1:0] d, input logic pe, input logic fe);
        word_t w;
        bit    empty;
        empty = (id == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL dut%0d unexpected word: got %0h, expected none", id, d);
        end else begin
            if (id == 0) w = exp_q0.pop_front();
            else         w = exp_q1.pop_front();
            checkOutput($sformatf("dut%0d data_out", id), 32'(d), 32'(w.data));
            checkOutput($sformatf("dut%0d parity_err", id), 32'(pe), 32'(w.perr));
            checkOutput($sformatf("dut%0d frame_err", id), 32'(fe), 32'(w.ferr));
        end
    endtask

    // Monitor: words are checked the moment the consumer takes them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ovr0) ovr_seen0++;
            if (ovr1) ovr_seen1++;
            if (valid0 && ready_in) checkWord(0, data0, perr0, ferr0);
            if (valid1 && ready_in) checkWord(1, data1, perr1, ferr1);
        end
    end

    task automatic idleTicks(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            ena = 1'b1;
            rx  = 1'b1;
        end
    endtask

    // Builds one frame tick by tick from the framing rules and records the
    // word the receiver should hand over (or the overrun it should report).
    task automatic applyStimulus(input logic [DW-1:0] data, input logic par_flip,
                                 input logic stop_bad, input int pause_bit,
                                 input int glitch_bit, input int ready_tick,
                                 input bit expect_drop, input bit check_lat,
                                 input int idle_ticks);
        logic       slots[$];
        logic [1:0] seq[$];
        logic       v;
        int         pause_len;
        word_t      w;
        pause_len = (pause_bit >= 0) ? 5 : 0;
        slots.push_back(1'b0);
        for (int i = 0; i < DW; i++) slots.push_back(data[i]);
        if (PM != 0) slots.push_back((^data) ^ (PM == 2) ^ par_flip);
        for (int i = 0; i < SB; i++) slots.push_back(1'b1);
        for (int s = 0; s < slots.size(); s++) begin
            for (int o = 0; o < OS; o++) begin
                v = slots[s];
                if (stop_bad && s == slots.size() - 1) v = (o == OS - 1);
                if (glitch_bit >= 0 && s == glitch_bit + 1 && o == M + 1) v = ~v;
                if (pause_bit >= 0 && s == pause_bit + 1 && o == M)
                    repeat (pause_len) seq.push_back({1'b0, v});
                seq.push_back({1'b1, v});
            end
        end
        repeat (idle_ticks) seq.push_back(2'b11);

        w.data = data;
        w.perr = (PM != 0) && par_flip;
        w.ferr = stop_bad;
        if (expect_drop) begin
            exp_ovr++;
        end else begin
            exp_q0.push_back(w);
            exp_q1.push_back(w);
        end

        for (int t = 0; t < seq.size(); t++) begin
            @(posedge clk);
            #1;
            {ena, rx} = seq[t];
            if (ready_tick >= 0) ready_in = (t == ready_tick);
            if (check_lat) begin
                if (t == LAT + pause_len) begin
                    checkOutput("valid_out before completion dut0", 32'(valid0), 32'd0);
                    checkOutput("valid_out before completion dut1", 32'(valid1), 32'd0);
                end
                if (t == LAT + 1 + pause_len) begin
                    checkOutput("valid_out at completion+1 dut0", 32'(valid0), 32'd1);
                    checkOutput("valid_out at completion+1 dut1", 32'(valid1), 32'd1);
                end
                if (t == LAT + 2 + pause_len) begin
                    checkOutput("valid_out cleared after accept dut0", 32'(valid0), 32'd0);
                    checkOutput("valid_out cleared after accept dut1", 32'(valid1), 32'd0);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_cnt0;
        int busy_cnt1;
        rst_n    = 1'b0;
        ena      = 1'b1;
        rx       = 1'b1;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset data_out", 32'(data0), 32'd0);
        checkOutput("reset valid_out", 32'(valid0), 32'd0);
        checkOutput("reset parity_err", 32'(perr0), 32'd0);
        checkOutput("reset frame_err", 32'(ferr0), 32'd0);
        checkOutput("reset overrun", 32'(ovr0), 32'd0);
        checkOutput("reset busy", 32'(busy0), 32'd0);
        checkOutput("reset valid_out inv", 32'(valid1), 32'd0);
        checkOutput("reset busy inv", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        idleTicks(6);
        checkOutput("idle busy after reset", 32'(busy0), 32'd0);
        checkOutput("idle busy after reset inv", 32'(busy1), 32'd0);

        $display("[TB] clean frame 55");
        applyStimulus(7'h55, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b1, 6);

        $display("[TB] false start");
        busy_cnt0 = 0;
        busy_cnt1 = 0;
        for (int t = 0; t < 24; t++) begin
            @(posedge clk);
            #1;
            rx = (t < 2) ? 1'b0 : 1'b1;
            if (busy0) busy_cnt0++;
            if (busy1) busy_cnt1++;
        end
        checkOutput("false start busy span dut0", 32'(busy_cnt0 >= 1 && busy_cnt0 <= 7), 32'd1);
        checkOutput("false start busy span dut1", 32'(busy_cnt1 >= 1 && busy_cnt1 <= 7), 32'd1);
        checkOutput("false start valid_out", 32'(valid0), 32'd0);
        checkOutput("false start busy end", 32'(busy0), 32'd0);

        $display("[TB] parity error frame");
        applyStimulus(7'h55, 1'b1, 1'b0, -1, -1, -1, 1'b0, 1'b1, 6);

        $display("[TB] framing error then back-to-back frame");
        applyStimulus(7'h2A, 1'b0, 1'b1, -1, -1, -1, 1'b0, 1'b0, 0);
        applyStimulus(7'h01, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b1, 6);

        $display("[TB] overrun with consumer stalled");
        ready_in = 1'b0;
        applyStimulus(7'h11, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0, 4);
        applyStimulus(7'h22, 1'b0, 1'b0, -1, -1, -1, 1'b1, 1'b0, 6);
        checkOutput("overrun count dut0", 32'(ovr_seen0), 32'(exp_ovr));
        checkOutput("overrun count dut1", 32'(ovr_seen1), 32'(exp_ovr));
        checkOutput("held word after overrun", 32'(data0), 32'h11);
        checkOutput("held valid after overrun", 32'(valid0), 32'd1);
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;

        $display("[TB] accept on completion cycle");
        applyStimulus(7'h11, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0, 4);
        applyStimulus(7'h22, 1'b0, 1'b0, -1, -1, LAT, 1'b0, 1'b0, 6);
        checkOutput("no overrun on same-cycle accept", 32'(ovr_seen0), 32'(exp_ovr));
        checkOutput("new word loaded", 32'(data0), 32'h22);
        checkOutput("new word valid", 32'(valid0), 32'd1);
        ready_in = 1'b1;
        idleTicks(4);

        $display("[TB] glitch plus ena pause");
        applyStimulus(7'h4B, 1'b0, 1'b0, 2, 3, -1, 1'b0, 1'b1, 12);

        $display("[TB] reset mid-frame");
        for (int t = 0; t < 30; t++) begin
            @(posedge clk);
            #1;
            rx = (t < 8) ? 1'b0 : t[3];
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        checkOutput("mid-frame reset busy", 32'(busy0), 32'd0);
        checkOutput("mid-frame reset valid_out", 32'(valid0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleTicks(100);
        checkOutput("after aborted frame valid_out", 32'(valid0), 32'd0);
        checkOutput("after aborted frame busy inv", 32'(busy1), 32'd0);

        $display("[TB] randomized frames");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(DW'($urandom), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0), -1, -1, -1, 1'b0, 1'b1,
                          int'($urandom_range(4, 7)));
        end

        idleTicks(20);
        checkOutput("scoreboard drained dut0", 32'(exp_q0.size()), 32'd0);
        checkOutput("scoreboard drained dut1", 32'(exp_q1.size()), 32'd0);
        checkOutput("final overrun count dut0", 32'(ovr_seen0), 32'(exp_ovr));
        checkOutput("final overrun count dut1", 32'(ovr_seen1), 32'(exp_ovr));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
